axi_lite_slave_mem: RTL

AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

---
 rtl/axi_lite_pkg.sv | 23 ++
 rtl/axi_lite_mem_array.sv | 66 ++++++
 rtl/axi_lite_slave_mem.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// ============================================================================
// Module : axi_lite_pkg
// Brief  : Response codes and FSM state encodings for the AXI-Lite memory slave
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_HAVE_ADDR = 2'd1;
    localparam logic [1:0] W_HAVE_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [0:0] R_IDLE      = 1'b0;
    localparam logic [0:0] R_DATA      = 1'b1;

endpackage

`default_nettype wire

// File: rtl/axi_lite_mem_array.sv
// ============================================================================
// Module : axi_lite_mem_array
// Brief  : Byte-enabled word storage, one write port, one registered read port
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_lite_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic [DATA_W/8-1:0] i_wr_strb,
    input  logic                i_rd_en,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic [DATA_W-1:0]   o_rd_data
);

    logic [DATA_W-1:0] r_mem_q [DEPTH];
    logic [DATA_W-1:0] w_mem_d [DEPTH];
    logic [DATA_W-1:0] r_rd_data_q;
    logic [DATA_W-1:0] w_rd_data_d;
    logic [DATA_W-1:0] w_merged;

    for (genvar b = 0; b < DATA_W/8; b++) begin : g_lane
        assign w_merged[b*8 +: 8] = i_wr_strb[b] ? i_wr_data[b*8 +: 8]
                                                 : r_mem_q[i_wr_idx][b*8 +: 8];
    end

    always_comb begin
        w_mem_d = r_mem_q;
        if (i_wr_en) begin
            w_mem_d[i_wr_idx] = w_merged;
        end
    end

    // Read samples the pre-write contents when a write lands on the same edge.
    always_comb begin
        w_rd_data_d = r_rd_data_q;
        if (i_rd_en) begin
            w_rd_data_d = r_mem_q[i_rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_rd_data_q <= '0;
        end else begin
            r_mem_q     <= w_mem_d;
            r_rd_data_q <= w_rd_data_d;
        end
    end

    assign o_rd_data = r_rd_data_q;

endmodule

`default_nettype wire

// File: rtl/axi_lite_slave_mem.sv
// ============================================================================
// Module : axi_lite_slave_mem
// Brief  : AXI4-Lite slave backed by a small byte-enabled register memory
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = OFF_W + IDX_W;

    logic [1:0]        r_wstate_q, w_wstate_d;
    logic [ADDR_W-1:0] r_awaddr_q, w_awaddr_d;
    logic [DATA_W-1:0] r_wdata_q,  w_wdata_d;
    logic [STRB_W-1:0] r_wstrb_q,  w_wstrb_d;
    logic              r_commit_q, w_commit_d;
    logic [0:0]        r_rstate_q, w_rstate_d;
    logic              r_rerr_q,   w_rerr_d;
    logic              r_rdy_q;

    logic              w_aw_hs, w_w_hs, w_ar_hs;
    logic              w_werr;
    logic [DATA_W-1:0] w_mem_rdata;
    logic              w_unused_ok;

    // Readies stay low until the first edge after reset release.
    assign AWREADY = r_rdy_q && (r_wstate_q == W_IDLE || r_wstate_q == W_HAVE_DATA);
    assign WREADY  = r_rdy_q && (r_wstate_q == W_IDLE || r_wstate_q == W_HAVE_ADDR);
    assign ARREADY = r_rdy_q && (r_rstate_q == R_IDLE);

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID  && WREADY;
    assign w_ar_hs = ARVALID && ARREADY;

    assign w_werr  = |r_awaddr_q[ADDR_W-1:HI_LSB];
    assign BVALID  = (r_wstate_q == W_RESP);
    assign BRESP   = (BVALID && w_werr) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        w_wstate_d = r_wstate_q;
        w_awaddr_d = w_aw_hs ? AWADDR : r_awaddr_q;
        w_wdata_d  = w_w_hs  ? WDATA  : r_wdata_q;
        w_wstrb_d  = w_w_hs  ? WSTRB  : r_wstrb_q;
        w_commit_d = 1'b0;
        case (r_wstate_q)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_d = W_RESP;
                    w_commit_d = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_d = W_HAVE_ADDR;
                end else if (w_w_hs) begin
                    w_wstate_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_w_hs) begin
                    w_wstate_d = W_RESP;
                    w_commit_d = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                if (w_aw_hs) begin
                    w_wstate_d = W_RESP;
                    w_commit_d = 1'b1;
                end
            end
            default: begin
                if (BREADY) begin
                    w_wstate_d = W_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_rstate_d = r_rstate_q;
        w_rerr_d   = r_rerr_q;
        if (r_rstate_q == R_IDLE) begin
            if (w_ar_hs) begin
                w_rstate_d = R_DATA;
                w_rerr_d   = |ARADDR[ADDR_W-1:HI_LSB];
            end
        end else if (RREADY) begin
            w_rstate_d = R_IDLE;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate_q <= W_IDLE;
            r_awaddr_q <= '0;
            r_wdata_q  <= '0;
            r_wstrb_q  <= '0;
            r_commit_q <= 1'b0;
            r_rstate_q <= R_IDLE;
            r_rerr_q   <= 1'b0;
            r_rdy_q    <= 1'b0;
        end else begin
            r_wstate_q <= w_wstate_d;
            r_awaddr_q <= w_awaddr_d;
            r_wdata_q  <= w_wdata_d;
            r_wstrb_q  <= w_wstrb_d;
            r_commit_q <= w_commit_d;
            r_rstate_q <= w_rstate_d;
            r_rerr_q   <= w_rerr_d;
            r_rdy_q    <= 1'b1;
        end
    end

    axi_lite_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk       (ACLK),
        .rst       (ARESET),
        .i_wr_en   (r_commit_q && !w_werr),
        .i_wr_idx  (r_awaddr_q[HI_LSB-1:OFF_W]),
        .i_wr_data (r_wdata_q),
        .i_wr_strb (r_wstrb_q),
        .i_rd_en   (w_ar_hs),
        .i_rd_idx  (ARADDR[HI_LSB-1:OFF_W]),
        .o_rd_data (w_mem_rdata)
    );

    assign RVALID = (r_rstate_q == R_DATA);
    assign RDATA  = r_rerr_q ? '0 : w_mem_rdata;
    assign RRESP  = r_rerr_q ? RESP_SLVERR : RESP_OKAY;

    // Byte-offset bits carry no meaning for word storage.
    assign w_unused_ok = ^{ARADDR[OFF_W-1:0], r_awaddr_q[OFF_W-1:0]};

endmodule

`default_nettype wire
